// File: rtl/regfile_ctx_engine_pkg.sv
// rtl/regfile_ctx_engine_pkg.sv - shared state encoding and constants for the context engine
package regfile_ctx_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_READ,
    S_REQ,
    R_REQ,
    R_WRITE,
    FIN
  } ctx_state_t;

  localparam logic MODE_SAVE    = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;
  localparam int   NUM_REGS     = 16;
  localparam int   IDX_W        = $clog2(NUM_REGS);

endpackage

// File: rtl/regfile_ctx_engine_ctx_addr_gen.sv
// rtl/regfile_ctx_engine_ctx_addr_gen.sv - register index / slot address counter with load, step and last flag
module ctx_addr_gen
  import regfile_ctx_engine_pkg::*;
#(
  parameter int FIRST_REG   = 1,
  parameter int LAST_REG    = 15,
  parameter int ADDR_STRIDE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [15:0]      i_base,
  output logic [IDX_W-1:0] o_idx,
  output logic [15:0]      o_addr,
  output logic             o_last
);

  localparam logic [15:0] STEP      = 16'(ADDR_STRIDE);
  localparam logic [15:0] FIRST_OFS = 16'(ADDR_STRIDE * FIRST_REG);

  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_addr;

  // Slot addresses wrap silently at 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_idx  <= IDX_W'(FIRST_REG);
      r_addr <= i_base + FIRST_OFS;
    end else if (i_step) begin
      r_idx  <= r_idx + 1'b1;
      r_addr <= r_addr + STEP;
    end
  end

  assign o_idx  = r_idx;
  assign o_addr = r_addr;
  assign o_last = (r_idx == IDX_W'(LAST_REG));

endmodule

// File: rtl/regfile_ctx_engine.sv
// rtl/regfile_ctx_engine.sv - register file context save/restore sequencer; CHECKSUM_EN adds the csum output
module regfile_ctx_engine
  import regfile_ctx_engine_pkg::*;
#(
  parameter int FIRST_REG   = 1,
  parameter int LAST_REG    = 15,
  parameter int ADDR_STRIDE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [15:0]      base_addr,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rf_src_reg,
  input  logic [15:0]      rf_src_data,
  output logic [IDX_W-1:0] rf_dst_reg,
  output logic [15:0]      rf_dst_data,
  output logic             rf_write_reg,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ready
`ifdef CHECKSUM_EN
  ,
  output logic [15:0]      csum
`endif
);

  ctx_state_t       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_mem_en;
  logic             r_mem_wr;
  logic             r_rf_write;
  logic             r_mode_q;
  logic [15:0]      r_data_q;

  logic [IDX_W-1:0] w_idx;
  logic [15:0]      w_addr;
  logic             w_last;
  logic             w_load;
  logic             w_step;

  assign w_load = (r_state == IDLE) && start;
  // Save advances after the memory write lands, restore after the register write.
  assign w_step = (r_mode_q == MODE_SAVE) ? ((r_state == S_REQ) && mem_ready && !w_last)
                                          : ((r_state == R_WRITE) && !w_last);

  ctx_addr_gen #(
    .FIRST_REG  (FIRST_REG),
    .LAST_REG   (LAST_REG),
    .ADDR_STRIDE(ADDR_STRIDE)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_step(w_step),
    .i_base(base_addr),
    .o_idx (w_idx),
    .o_addr(w_addr),
    .o_last(w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_rf_write <= 1'b0;
      r_mode_q   <= MODE_SAVE;
      r_data_q   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rf_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode_q <= mode;
            r_busy   <= 1'b1;
            if (mode == MODE_RESTORE) begin
              r_state  <= R_REQ;
              r_mem_en <= 1'b1;
              r_mem_wr <= 1'b0;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_data_q <= rf_src_data;
          r_state  <= S_REQ;
          r_mem_en <= 1'b1;
          r_mem_wr <= 1'b1;
        end
        S_REQ: begin
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            if (w_last) begin
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        R_REQ: begin
          if (mem_ready) begin
            r_data_q   <= mem_rdata;
            r_mem_en   <= 1'b0;
            r_rf_write <= 1'b1;
            r_state    <= R_WRITE;
          end
        end
        R_WRITE: begin
          if (w_last) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state  <= R_REQ;
            r_mem_en <= 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_csum <= '0;
    end else if ((r_state == S_REQ) && mem_ready) begin
      r_csum <= r_csum + r_data_q;
    end else if ((r_state == R_REQ) && mem_ready) begin
      r_csum <= r_csum + mem_rdata;
    end
  end

  assign csum = r_csum;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign rf_src_reg   = w_idx;
  assign rf_dst_reg   = w_idx;
  assign rf_dst_data  = r_data_q;
  assign rf_write_reg = r_rf_write;
  assign mem_en       = r_mem_en;
  assign mem_wr       = r_mem_wr;
  assign mem_addr     = w_addr;
  assign mem_wdata    = r_data_q;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// tb/tb_regfile_ctx_engine.sv - scoreboard bench for regfile_ctx_engine; honours CHECKSUM_EN
module tb_regfile_ctx_engine;

  localparam int FIRST  = 1;
  localparam int LAST   = 15;
  localparam int STRIDE = 2;
  localparam int NXFER  = LAST - FIRST + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] base_addr = 16'h0;
  logic        busy, done;
  logic [3:0]  rf_src_reg, rf_dst_reg;
  logic [15:0] rf_src_data, rf_dst_data;
  logic        rf_write_reg, mem_en, mem_wr, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CHECKSUM_EN
  logic [15:0] csum;
`endif

  regfile_ctx_engine #(.FIRST_REG(FIRST), .LAST_REG(LAST), .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .busy(busy), .done(done),
    .rf_src_reg(rf_src_reg), .rf_src_data(rf_src_data),
    .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data), .rf_write_reg(rf_write_reg),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CHECKSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] rf  [16];
  logic [15:0] mem [65536];
  int wait_cfg = 0;
  int wcnt = 0;

  assign rf_src_data = rf[rf_src_reg];
  assign mem_rdata   = mem[mem_addr];
  assign mem_ready   = mem_en && (wcnt >= wait_cfg);

  always @(posedge clk) begin
    if (mem_en && mem_wr && mem_ready) mem[mem_addr] = mem_wdata;
    if (rf_write_reg) rf[rf_dst_reg] = rf_dst_data;
    wcnt <= (mem_en && !mem_ready) ? wcnt + 1 : 0;
  end

  typedef struct { logic [15:0] addr; logic wr; logic [15:0] data; } mem_tx_t;
  typedef struct { logic [3:0] rd; logic [15:0] data; } rf_tx_t;
  mem_tx_t exp_mem[$];
  rf_tx_t  exp_rf[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        prev_wait = 1'b0;
  logic        prev_wr = 1'b0;
  logic [15:0] prev_addr = 16'h0, prev_wdata = 16'h0;

  // Monitor: pops expected transfers whenever the DUT completes one.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_wait && mem_en) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_wr", mem_wr, prev_wr);
        if (mem_wr) chk("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_en && mem_ready) begin
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got addr %0h wr %0b expected none", mem_addr, mem_wr);
        end else begin
          mem_tx_t t;
          t = exp_mem.pop_front();
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_wr", mem_wr, t.wr);
          if (t.wr) chk("mem_wdata", mem_wdata, t.data);
        end
      end
      if (rf_write_reg) begin
        if (exp_rf.size() == 0) begin
          total++; bad++;
          $display("FAIL rf_unexpected: got R%0d=%0h expected none", rf_dst_reg, rf_dst_data);
        end else begin
          rf_tx_t r;
          r = exp_rf.pop_front();
          chk("rf_dst_reg", rf_dst_reg, r.rd);
          chk("rf_dst_data", rf_dst_data, r.data);
        end
      end
      if (done) done_cnt++;
    end
    prev_wait  = mem_en && !mem_ready;
    prev_addr  = mem_addr;
    prev_wr    = mem_wr;
    prev_wdata = mem_wdata;
  end

  function automatic logic [15:0] slot(input logic [15:0] b, input int n);
    return 16'(b + STRIDE * n);
  endfunction

  task automatic expect_op(input logic m, input logic [15:0] b, output logic [15:0] sum);
    sum = 16'h0;
    for (int n = FIRST; n <= LAST; n++) begin
      if (m == 1'b0) begin
        exp_mem.push_back('{addr: slot(b, n), wr: 1'b1, data: rf[n]});
        sum = sum + rf[n];
      end else begin
        exp_mem.push_back('{addr: slot(b, n), wr: 1'b0, data: 16'h0});
        exp_rf.push_back('{rd: 4'(n), data: mem[slot(b, n)]});
        sum = sum + mem[slot(b, n)];
      end
    end
  endtask

  task automatic issue_start(input logic m, input logic [15:0] b);
    @(posedge clk); #1;
    mode = m; base_addr = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); base_addr = 16'($urandom);
  endtask

  task automatic run_op(input logic m, input logic [15:0] b, input int w);
    logic [15:0] sum;
    logic [15:0] snap [16];
    int k;
    for (int n = 0; n < 16; n++) snap[n] = (m == 1'b0) ? rf[n] : mem[slot(b, n)];
    wait_cfg = w;
    done_cnt = 0;
    expect_op(m, b, sum);
    issue_start(m, b);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
`ifdef CHECKSUM_EN
    chk("csum_cleared", csum, 0);
`endif
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
      return;
    end
    chk("latency", k + 1, NXFER * (2 + w) + 1);
    chk("busy_at_done", busy, 0);
`ifdef CHECKSUM_EN
    chk("csum_final", csum, sum);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("done_count", done_cnt, 1);
    chk("mem_q_left", exp_mem.size(), 0);
    chk("rf_q_left", exp_rf.size(), 0);
    for (int n = FIRST; n <= LAST; n++) begin
      if (m == 1'b0) chk("saved_word", mem[slot(b, n)], snap[n]);
      else           chk("restored_reg", rf[n], snap[n]);
    end
    chk("r0_untouched", rf[0], 0);
  endtask

  task automatic reset_abort_test();
    logic [15:0] sum;
    logic [15:0] b;
    int k;
    b = 16'h4000;
    for (int n = 1; n < 16; n++) begin
      rf[n] = 16'h5500 + 16'(n);
      mem[slot(b, n)] = 16'hC000 + 16'(n);
    end
    wait_cfg = 1;
    done_cnt = 0;
    expect_op(1'b1, b, sum);
    issue_start(1'b1, b);
    repeat (3) @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 16'h9000;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_en && mem_addr == slot(b, 5)) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      total++; bad++;
      $display("FAIL idx5_timeout: got no R5 request expected one");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_mem.delete();
    exp_rf.delete();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_rf_write", rf_write_reg, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    for (int n = 1; n < 16; n++)
      chk("abort_reg", rf[n], (n < 5) ? 16'hC000 + 16'(n) : 16'h5500 + 16'(n));
  endtask

  initial begin
    for (int n = 0; n < 16; n++) rf[n] = 16'h0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_rf_write", rf_write_reg, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_src_reg", rf_src_reg, 0);
    chk("rst_dst_reg", rf_dst_reg, 0);
    chk("rst_dst_data", rf_dst_data, 0);
`ifdef CHECKSUM_EN
    chk("rst_csum", csum, 0);
`endif

    for (int n = 1; n < 16; n++) rf[n] = 16'h1100 + 16'(n);
    run_op(1'b0, 16'h1000, 0);

    for (int n = 1; n < 16; n++) mem[slot(16'h2000, n)] = 16'hA000 + 16'(n);
    run_op(1'b1, 16'h2000, 0);

    run_op(1'b0, 16'h3000, 3);
    run_op(1'b0, 16'hFFF0, 0);

    for (int n = 1; n < 16; n++) rf[n] = 16'(n);
    run_op(1'b0, 16'h5000, 1);

    for (int i = 0; i < 6; i++) begin
      logic        m;
      logic [15:0] b;
      m = 1'($urandom);
      b = 16'($urandom);
      for (int n = 1; n < 16; n++) begin
        rf[n] = 16'($urandom);
        mem[slot(b, n)] = 16'($urandom);
      end
      run_op(m, b, int'($urandom_range(0, 2)));
    end

    reset_abort_test();

    for (int n = 1; n < 16; n++) rf[n] = 16'h7700 + 16'(n);
    run_op(1'b0, 16'h6000, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
